// File: rtl/tick_scheduler_if.sv
// Configuration port of tick_scheduler: one valid/ready write of period and enable to a channel.
interface tick_scheduler_if #(
    parameter int PERIOD_W = 16
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [2:0]          cfg_ch;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_enable;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_period,
        output cfg_enable,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_period,
        input  cfg_enable,
        output cfg_ready
    );
endinterface

// File: rtl/tick_scheduler.sv
// Shared timebase: one prescaler producing base_tick, NUM_CH programmable channel tick enables.
// Optional TICK_SCHED_SQUARE_EN adds a per-channel square output toggling on every channel tick.
module tick_scheduler #(
    parameter logic [31:0] PRESCALE = 32'd2500,
    parameter int          NUM_CH   = 4,
    parameter int          PERIOD_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sync,
    tick_scheduler_if.slave   cfg,
    output logic              base_tick,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] active
`ifdef TICK_SCHED_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] square
`endif
);

    // state   | meaning
    // IDLE    | cfg_ready high, waiting for a config request
    // APPLY   | latched request written into the channel registers
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    localparam logic [31:0] PRE_LAST = PRESCALE - 32'd1;

    state_t              state_q, state_d;
    logic [2:0]          lat_ch_q, lat_ch_d;
    logic [PERIOD_W-1:0] lat_period_q, lat_period_d;
    logic                lat_enable_q, lat_enable_d;

    logic [31:0]         pre_cnt_q, pre_cnt_d;
    logic                base_tick_q, base_tick_d;
    logic [PERIOD_W-1:0] period_q [NUM_CH];
    logic [PERIOD_W-1:0] period_d [NUM_CH];
    logic [PERIOD_W-1:0] ch_cnt_q [NUM_CH];
    logic [PERIOD_W-1:0] ch_cnt_d [NUM_CH];
    logic [NUM_CH-1:0]   enable_q, enable_d;
    logic [NUM_CH-1:0]   active_q, active_d;
    logic [NUM_CH-1:0]   tick_q, tick_d;
`ifdef TICK_SCHED_SQUARE_EN
    logic [NUM_CH-1:0]   square_q, square_d;
`endif

    logic strobe;
    logic apply;

    always_comb begin
        state_d      = state_q;
        lat_ch_d     = lat_ch_q;
        lat_period_d = lat_period_q;
        lat_enable_d = lat_enable_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg.cfg_valid) begin
                    lat_ch_d     = cfg.cfg_ch;
                    lat_period_d = cfg.cfg_period;
                    lat_enable_d = cfg.cfg_enable;
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign cfg.cfg_ready = (state_q == ST_IDLE);
    assign apply         = (state_q == ST_APPLY);

    // sync realigns the prescaler and swallows the strobe of its own edge
    assign strobe = (pre_cnt_q == PRE_LAST) && !sync;

    always_comb begin
        pre_cnt_d   = (sync || pre_cnt_q == PRE_LAST) ? 32'd0 : pre_cnt_q + 32'd1;
        base_tick_d = strobe;
        enable_d    = enable_q;
        active_d    = active_q;
        tick_d      = '0;
`ifdef TICK_SCHED_SQUARE_EN
        square_d    = square_q;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            period_d[c] = period_q[c];
            ch_cnt_d[c] = ch_cnt_q[c];
            if (strobe && active_q[c]) begin
                if (ch_cnt_q[c] == period_q[c] - PERIOD_W'(1)) begin
                    ch_cnt_d[c] = '0;
                    tick_d[c]   = 1'b1;
`ifdef TICK_SCHED_SQUARE_EN
                    square_d[c] = ~square_q[c];
`endif
                end else begin
                    ch_cnt_d[c] = ch_cnt_q[c] + PERIOD_W'(1);
                end
            end
            if (sync) begin
                ch_cnt_d[c] = '0;
`ifdef TICK_SCHED_SQUARE_EN
                square_d[c] = 1'b0;
`endif
            end
            // indices >= NUM_CH never match, so out-of-range writes fall through
            if (apply && lat_ch_q == 3'(c)) begin
                period_d[c] = lat_period_q;
                enable_d[c] = lat_enable_q;
                ch_cnt_d[c] = '0;
                active_d[c] = lat_enable_q && (lat_period_q != '0);
`ifdef TICK_SCHED_SQUARE_EN
                if (!(lat_enable_q && (lat_period_q != '0))) begin
                    square_d[c] = 1'b0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lat_ch_q     <= '0;
            lat_period_q <= '0;
            lat_enable_q <= 1'b0;
            pre_cnt_q    <= '0;
            base_tick_q  <= 1'b0;
            period_q     <= '{default: '0};
            ch_cnt_q     <= '{default: '0};
            enable_q     <= '0;
            active_q     <= '0;
            tick_q       <= '0;
`ifdef TICK_SCHED_SQUARE_EN
            square_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lat_ch_q     <= lat_ch_d;
            lat_period_q <= lat_period_d;
            lat_enable_q <= lat_enable_d;
            pre_cnt_q    <= pre_cnt_d;
            base_tick_q  <= base_tick_d;
            period_q     <= period_d;
            ch_cnt_q     <= ch_cnt_d;
            enable_q     <= enable_d;
            active_q     <= active_d;
            tick_q       <= tick_d;
`ifdef TICK_SCHED_SQUARE_EN
            square_q     <= square_d;
`endif
        end
    end

    assign base_tick = base_tick_q;
    assign tick      = tick_q;
    assign active    = active_q;
`ifdef TICK_SCHED_SQUARE_EN
    assign square    = square_q;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios plus random traffic against a count-based reference model.
module tb_tick_scheduler;
    localparam logic [31:0] PRE = 32'd4;
    localparam int          PI  = 4;
    localparam int          NCH = 4;
    localparam int          PW  = 16;

    logic           clock = 1'b0;
    logic           reset;
    logic           sync;
    logic           base_tick;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] active;
`ifdef TICK_SCHED_SQUARE_EN
    logic [NCH-1:0] square;
`endif

    tick_scheduler_if #(.PERIOD_W(PW)) cfg_if ();

    tick_scheduler #(.PRESCALE(PRE), .NUM_CH(NCH), .PERIOD_W(PW)) dut (
        .clock     (clock),
        .reset     (reset),
        .sync      (sync),
        .cfg       (cfg_if),
        .base_tick (base_tick),
        .tick      (tick),
        .active    (active)
`ifdef TICK_SCHED_SQUARE_EN
        ,
        .square    (square)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_err  = 0;
    int edge_n = 0;

    // reference model: edges since alignment, strobes since each channel's last clear
    int           m_align;
    int           m_per [NCH];
    int           m_str [NCH];
    bit [NCH-1:0] m_en, m_act, m_tick, m_sq;
    bit           m_base, m_ready, m_pend, m_pen;
    int           m_pch, m_pper;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_step();
        bit strobe;
        if (reset) begin
            m_align = 0; m_en = '0; m_act = '0; m_tick = '0; m_sq = '0;
            m_base = 0; m_ready = 1; m_pend = 0;
            for (int c = 0; c < NCH; c++) begin m_per[c] = 0; m_str[c] = 0; end
            return;
        end
        m_align++;
        strobe = (m_align % PI == 0) && !sync;
        if (sync) m_align = 0;
        m_base = strobe;
        m_tick = '0;
        for (int c = 0; c < NCH; c++) begin
            if (strobe && m_act[c]) begin
                m_str[c]++;
                if (m_str[c] % m_per[c] == 0) begin
                    m_tick[c] = 1'b1;
                    m_sq[c]   = ~m_sq[c];
                end
            end
            if (sync) begin m_str[c] = 0; m_sq[c] = 1'b0; end
        end
        if (m_pend) begin
            if (m_pch < NCH) begin
                m_per[m_pch] = m_pper;
                m_en[m_pch]  = m_pen;
                m_str[m_pch] = 0;
                m_act[m_pch] = m_pen && (m_pper != 0);
                if (!m_act[m_pch]) m_sq[m_pch] = 1'b0;
            end
            m_pend  = 0;
            m_ready = 1;
        end else if (cfg_if.cfg_valid && m_ready) begin
            m_pend  = 1;
            m_pch   = int'(cfg_if.cfg_ch);
            m_pper  = int'(cfg_if.cfg_period);
            m_pen   = cfg_if.cfg_enable;
            m_ready = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        edge_n++;
        model_step();
        #1;
        check_val("base_tick", base_tick, m_base);
        check_val("tick", tick, m_tick);
        check_val("active", active, m_act);
        check_val("cfg_ready", cfg_if.cfg_ready, m_ready);
`ifdef TICK_SCHED_SQUARE_EN
        check_val("square", square, m_sq);
`endif
    endtask

    task automatic cfg_write(input int ch, input int per, input bit en);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 3'(ch);
        cfg_if.cfg_period = 16'(per);
        cfg_if.cfg_enable = en;
        cycle();
        cfg_if.cfg_valid  = 1'b0;
        cycle();
    endtask

    initial begin
        int first, second, sync_edge, apply_edge, t3_seen;
        reset = 1'b1; sync = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_period = '0; cfg_if.cfg_enable = 1'b0;
        cycle();
        reset = 1'b0;

        // idle prescaler: first base tick at edge 5 counting the reset edge as edge 1
        first = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (base_tick && first == 0) first = edge_n;
        end
        check_val("first_base_edge", first, 5);

        // ch0 period 3
        cfg_write(0, 3, 1);
        check_val("ch0_active", active[0], 1);
        first = 0; second = 0;
        for (int i = 0; i < 40 && second == 0; i++) begin
            cycle();
            if (tick[0]) begin
                if (first == 0) first = edge_n; else second = edge_n;
            end
        end
        check_val("tick0_gap", second - first, 12);

        // sync with ch1 period 1 and ch2 period 2 running
        cfg_write(1, 1, 1);
        cfg_write(2, 2, 1);
        for (int i = 0; i < 6; i++) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        sync_edge = edge_n;
        check_val("sync_no_base", base_tick, 0);
        first = 0;
        for (int i = 0; i < 10 && first == 0; i++) begin
            cycle();
            if (base_tick) first = edge_n;
        end
        check_val("sync_next_base", first - sync_edge, 4);
        check_val("sync_tick1", tick[1], 1);
        check_val("sync_tick2_early", tick[2], 0);
        for (int i = 0; i < 4; i++) cycle();
        check_val("sync_tick2_late", tick[2], 1);

        // rewrite ch0 to period 5 so that APPLY lands on an expiry
        for (int i = 0; i < 40; i++) begin
            if ((m_align + 2) % PI == 0 && m_act[0] && (m_str[0] + 1) % m_per[0] == 0) break;
            cycle();
        end
        cfg_write(0, 5, 1);
        apply_edge = edge_n;
        check_val("apply_old_tick", tick[0], 1);
        first = 0;
        for (int i = 0; i < 40 && first == 0; i++) begin
            cycle();
            if (tick[0]) first = edge_n;
        end
        check_val("apply_new_gap", first - apply_edge, 20);

        // out-of-range channel and zero period
        cfg_write(6, 7, 1);
        cfg_write(3, 0, 1);
        t3_seen = 0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (tick[3]) t3_seen++;
        end
        check_val("ch3_inactive", active[3], 0);
        check_val("ch3_no_tick", t3_seen, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset             = ($urandom_range(0, 199) == 0);
            sync              = ($urandom_range(0, 31) == 0);
            cfg_if.cfg_valid  = ($urandom_range(0, 5) == 0);
            cfg_if.cfg_ch     = 3'($urandom_range(0, 7));
            cfg_if.cfg_period = 16'($urandom_range(0, 4));
            cfg_if.cfg_enable = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        reset = 1'b0; sync = 1'b0; cfg_if.cfg_valid = 1'b0;
        cycle();

        // reset while APPLY pending
        cfg_write(0, 3, 1);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 3'd1; cfg_if.cfg_period = 16'd2; cfg_if.cfg_enable = 1'b1;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_val("rst_ready", cfg_if.cfg_ready, 1);
        check_val("rst_active", active, 0);
        check_val("rst_tick", tick, 0);
        for (int i = 0; i < 8; i++) cycle();
        check_val("rst_apply_dropped", active, 0);

`ifdef TICK_SCHED_SQUARE_EN
        begin
            logic prev_sq;
            cfg_write(0, 3, 1);
            prev_sq = square[0]; first = 0; second = 0;
            for (int i = 0; i < 60 && second == 0; i++) begin
                cycle();
                if (square[0] != prev_sq) begin
                    if (first == 0) first = edge_n; else second = edge_n;
                end
                prev_sq = square[0];
            end
            check_val("square_gap", second - first, 12);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
